// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler feeding four programmable tick channels whose
// periods are reconfigured only at period boundaries. Clk_out built under TICK_SCHEDULER_CLKOUT_EN.
module tick_scheduler #(
    parameter logic [24:0] BASE_DIV = 25'd249_999
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Cfg_valid,
    output logic       Cfg_ready,
    input  logic [1:0] Cfg_ch,
    input  logic [7:0] Cfg_div,
    input  logic       Cfg_en,
    output logic [3:0] Tick,
    output logic       Pending,
    output logic       Clk_out
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [24:0] pcnt;
    logic        base_tick;
    logic [0:0]  state;
    logic [1:0]  sh_ch;
    logic [7:0]  sh_div;
    logic        sh_en;
    logic [7:0]  div [4];
    logic [7:0]  cnt [4];
    logic [3:0]  en;
    logic [3:0]  boundary;
    logic        commit;

    assign base_tick = Enable && (pcnt == BASE_DIV);
    assign Cfg_ready = (state == ST_IDLE);
    assign Pending   = (state == ST_WAIT);

    // A channel hits its boundary on the base tick where its count reaches its divider.
    always_comb begin
        boundary = '0;
        for (int i = 0; i < 4; i++) begin
            boundary[i] = base_tick && en[i] && (cnt[i] == div[i]);
        end
    end

    // A disabled target can take the new setting at once; an enabled one waits for its boundary.
    assign commit = (state == ST_WAIT) && (!en[sh_ch] || boundary[sh_ch]);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pcnt <= '0;
        end else if (Enable) begin
            pcnt <= (pcnt == BASE_DIV) ? '0 : pcnt + 25'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= ST_IDLE;
            sh_ch  <= '0;
            sh_div <= '0;
            sh_en  <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (Cfg_valid) begin
                sh_ch  <= Cfg_ch;
                sh_div <= Cfg_div;
                sh_en  <= Cfg_en;
                state  <= ST_WAIT;
            end
        end else if (commit) begin
            state <= ST_IDLE;
        end
    end

    // The boundary tick still fires with the old period; the commit restarts the count.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Tick <= '0;
            en   <= '0;
            for (int i = 0; i < 4; i++) begin
                div[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            Tick <= boundary;
            for (int i = 0; i < 4; i++) begin
                if (commit && (sh_ch == 2'(i))) begin
                    div[i] <= sh_div;
                    en[i]  <= sh_en;
                    cnt[i] <= '0;
                end else if (base_tick && en[i]) begin
                    cnt[i] <= boundary[i] ? 8'd0 : cnt[i] + 8'd1;
                end
            end
        end
    end

`ifdef TICK_SCHEDULER_CLKOUT_EN
    logic clk_out_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_out_q <= 1'b0;
        end else if (boundary[0]) begin
            clk_out_q <= ~clk_out_q;
        end
    end

    assign Clk_out = clk_out_q;
`else
    assign Clk_out = 1'b0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler (BASE_DIV=3): directed scenarios plus a
// randomized run compared against a behavioural model built on enabled-cycle counts.
module tb_tick_scheduler;
    localparam int BD = 3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Enable = 1'b0;
    logic       Cfg_valid = 1'b0;
    logic [1:0] Cfg_ch = 2'd0;
    logic [7:0] Cfg_div = 8'd0;
    logic       Cfg_en = 1'b0;
    logic       Cfg_ready;
    logic [3:0] Tick;
    logic       Pending;
    logic       Clk_out;

    int errors = 0;
    int checks = 0;
    int ncyc = 0;

    tick_scheduler #(.BASE_DIV(25'd3)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Cfg_valid(Cfg_valid),
        .Cfg_ready(Cfg_ready), .Cfg_ch(Cfg_ch), .Cfg_div(Cfg_div), .Cfg_en(Cfg_en),
        .Tick(Tick), .Pending(Pending), .Clk_out(Clk_out)
    );

    always #5 Clk = ~Clk;

    // Reference model: base ticks from a count of enabled cycles, channels as
    // "base ticks remaining until the next pulse", one pending request slot.
    int         m_phase;
    int         m_rem [4];
    int         m_div [4];
    bit         m_en [4];
    bit         m_pend;
    int         m_ch;
    int         m_sdiv;
    bit         m_sen;
    logic [3:0] m_tick;
    logic       m_clk;

    always @(posedge Clk) begin : model
        bit         bt;
        bit         do_commit;
        logic [3:0] nt;
        if (Reset) begin
            m_phase = 0;
            for (int i = 0; i < 4; i++) begin
                m_rem[i] = 0;
                m_div[i] = 0;
                m_en[i]  = 0;
            end
            m_pend = 0;
            m_tick = 4'd0;
            m_clk  = 1'b0;
        end else begin
            bt = Enable && ((m_phase % (BD + 1)) == BD);
            if (Enable) m_phase++;
            do_commit = m_pend && (!m_en[m_ch] || (bt && m_rem[m_ch] == 0));
            nt = 4'd0;
            for (int i = 0; i < 4; i++) begin
                if (bt && m_en[i]) begin
                    if (m_rem[i] == 0) begin
                        nt[i] = 1'b1;
                        m_rem[i] = m_div[i];
                    end else begin
                        m_rem[i] = m_rem[i] - 1;
                    end
                end
            end
            if (do_commit) begin
                m_div[m_ch] = m_sdiv;
                m_en[m_ch]  = m_sen;
                m_rem[m_ch] = m_sdiv;
                m_pend = 0;
            end else if (!m_pend && Cfg_valid) begin
                m_ch   = int'(Cfg_ch);
                m_sdiv = int'(Cfg_div);
                m_sen  = Cfg_en;
                m_pend = 1;
            end
            m_tick = nt;
`ifdef TICK_SCHEDULER_CLKOUT_EN
            if (nt[0]) m_clk = ~m_clk;
`endif
        end
    end

    task automatic cyc();
        @(posedge Clk);
        @(negedge Clk);
        ncyc++;
    endtask

    task automatic wait_tick(input logic [1:0] ch, input int limit, output bit ok);
        ok = 0;
        for (int k = 0; k < limit; k++) begin
            cyc();
            if (Tick[ch] === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Enable = 1'b1;
        Cfg_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cyc();
            checks++;
            if ({Tick, Pending, Cfg_ready, Clk_out} !== 7'b0000_0_1_0) begin
                errors++;
                $display("[TB] FAIL reset_outputs: got %b expected 0000010", {Tick, Pending, Cfg_ready, Clk_out});
            end
        end
        Reset = 1'b0;
        for (int k = 0; k < 200; k++) begin
            cyc();
            checks++;
            if ({Tick, Pending, Cfg_ready, Clk_out} !== 7'b0000_0_1_0) begin
                errors++;
                $display("[TB] FAIL idle_after_reset cycle %0d: got %b expected 0000010", k, {Tick, Pending, Cfg_ready, Clk_out});
            end
        end
    endtask

    task automatic test_basic_period();
        bit ok;
        int gap;
        Cfg_valid = 1'b1; Cfg_ch = 2'd1; Cfg_div = 8'd2; Cfg_en = 1'b1;
        cyc();
        Cfg_valid = 1'b0;
        checks++;
        if (Pending !== 1'b1 || Cfg_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL transfer_wait: got pend=%b rdy=%b expected pend=1 rdy=0", Pending, Cfg_ready);
        end
        cyc();
        checks++;
        if (Pending !== 1'b0 || Cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL disabled_commit: got pend=%b rdy=%b expected pend=0 rdy=1", Pending, Cfg_ready);
        end
        wait_tick(2'd1, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL first_tick1: got timeout expected a pulse within 20 cycles");
        end
        for (int n = 0; n < 3; n++) begin
            gap = 0;
            do begin cyc(); gap++; end while (Tick[1] !== 1'b1 && gap < 40);
            checks++;
            if (gap != 12) begin
                errors++;
                $display("[TB] FAIL period_div2: got %0d expected 12", gap);
            end
        end
    endtask

    task automatic test_boundary_commit();
        bit ok;
        int gap;
        wait_tick(2'd1, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL sync_tick1: got timeout expected a pulse within 20 cycles");
        end
        Cfg_valid = 1'b1; Cfg_ch = 2'd1; Cfg_div = 8'd0; Cfg_en = 1'b1;
        cyc();
        gap = 1;
        Cfg_div = 8'd7;
        while (Tick[1] !== 1'b1 && gap < 40) begin
            checks++;
            if (Pending !== 1'b1 || Cfg_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL held_pending: got pend=%b rdy=%b expected pend=1 rdy=0", Pending, Cfg_ready);
            end
            cyc();
            gap++;
        end
        Cfg_valid = 1'b0;
        checks++;
        if (gap != 12) begin
            errors++;
            $display("[TB] FAIL boundary_old_period: got %0d expected 12", gap);
        end
        checks++;
        if (Pending !== 1'b0 || Cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL boundary_commit: got pend=%b rdy=%b expected pend=0 rdy=1", Pending, Cfg_ready);
        end
        for (int n = 0; n < 2; n++) begin
            gap = 0;
            do begin cyc(); gap++; end while (Tick[1] !== 1'b1 && gap < 40);
            checks++;
            if (gap != 4) begin
                errors++;
                $display("[TB] FAIL period_div0: got %0d expected 4", gap);
            end
        end
    endtask

    task automatic test_enable_hold();
        bit ok;
        int gap;
        Cfg_valid = 1'b1; Cfg_ch = 2'd2; Cfg_div = 8'd3; Cfg_en = 1'b1;
        cyc();
        Cfg_valid = 1'b0;
        cyc();
        wait_tick(2'd2, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL first_tick2: got timeout expected a pulse within 40 cycles");
        end
        for (int k = 0; k < 3; k++) cyc();
        Cfg_valid = 1'b1; Cfg_ch = 2'd2; Cfg_div = 8'd1; Cfg_en = 1'b1;
        cyc();
        Cfg_valid = 1'b0;
        Enable = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            checks++;
            if (Tick !== 4'd0 || Pending !== 1'b1) begin
                errors++;
                $display("[TB] FAIL hold_frozen: got tick=%b pend=%b expected tick=0000 pend=1", Tick, Pending);
            end
        end
        Enable = 1'b1;
        gap = 0;
        do begin cyc(); gap++; end while (Tick[2] !== 1'b1 && gap < 40);
        checks++;
        if (gap != 12) begin
            errors++;
            $display("[TB] FAIL hold_resume_phase: got %0d expected 12", gap);
        end
        checks++;
        if (Pending !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_commit: got pend=%b expected 0", Pending);
        end
        gap = 0;
        do begin cyc(); gap++; end while (Tick[2] !== 1'b1 && gap < 40);
        checks++;
        if (gap != 8) begin
            errors++;
            $display("[TB] FAIL period_div1: got %0d expected 8", gap);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        wait_tick(2'd2, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL sync_tick2: got timeout expected a pulse within 20 cycles");
        end
        Cfg_valid = 1'b1; Cfg_ch = 2'd2; Cfg_div = 8'd5; Cfg_en = 1'b1;
        cyc();
        Cfg_valid = 1'b0;
        cyc();
        checks++;
        if (Pending !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pending_before_reset: got %b expected 1", Pending);
        end
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        checks++;
        if ({Tick, Pending, Cfg_ready, Clk_out} !== 7'b0000_0_1_0) begin
            errors++;
            $display("[TB] FAIL mid_wait_reset: got %b expected 0000010", {Tick, Pending, Cfg_ready, Clk_out});
        end
        for (int k = 0; k < 100; k++) begin
            cyc();
            checks++;
            if (Tick !== 4'd0 || Pending !== 1'b0 || Cfg_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL discarded_cfg: got tick=%b pend=%b rdy=%b expected 0000 0 1", Tick, Pending, Cfg_ready);
            end
        end
    endtask

    task automatic test_clk_out();
        bit   ok;
        int   since;
        logic exp;
        Cfg_valid = 1'b1; Cfg_ch = 2'd0; Cfg_div = 8'd1; Cfg_en = 1'b1;
        cyc();
        Cfg_valid = 1'b0;
        cyc();
        wait_tick(2'd0, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL first_tick0: got timeout expected a pulse within 20 cycles");
        end
`ifdef TICK_SCHEDULER_CLKOUT_EN
        exp = 1'b1;
`else
        exp = 1'b0;
`endif
        checks++;
        if (Clk_out !== exp) begin
            errors++;
            $display("[TB] FAIL clk_out_first: got %b expected %b", Clk_out, exp);
        end
        since = 0;
        for (int k = 0; k < 32; k++) begin
            cyc();
            since++;
            if (Tick[0] === 1'b1) begin
                checks++;
                if (since != 8) begin
                    errors++;
                    $display("[TB] FAIL tick0_period: got %0d expected 8", since);
                end
                since = 0;
`ifdef TICK_SCHEDULER_CLKOUT_EN
                exp = ~exp;
`endif
            end
            checks++;
            if (Clk_out !== exp) begin
                errors++;
                $display("[TB] FAIL clk_out_wave: got %b expected %b", Clk_out, exp);
            end
        end
    endtask

    task automatic test_random();
        bit was_ready;
        for (int k = 0; k < 3000; k++) begin
            Enable = ($urandom_range(0, 7) != 0);
            Reset  = ($urandom_range(0, 999) == 0);
            if (!Cfg_valid) begin
                Cfg_valid = ($urandom_range(0, 3) == 0);
                Cfg_ch    = 2'($urandom_range(0, 3));
                Cfg_div   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
                Cfg_en    = ($urandom_range(0, 4) != 0);
            end
            was_ready = Cfg_ready;
            cyc();
            if (Cfg_valid && (was_ready || Reset)) Cfg_valid = 1'b0;
            checks++;
            if ({Tick, Pending, Cfg_ready, Clk_out} !== {m_tick, m_pend, !m_pend, m_clk}) begin
                errors++;
                $display("[TB] FAIL random_cycle %0d: got %b expected %b", k,
                         {Tick, Pending, Cfg_ready, Clk_out}, {m_tick, m_pend, !m_pend, m_clk});
            end
        end
        Reset = 1'b0;
        Cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_period();
        test_boundary_commit();
        test_enable_hold();
        test_reset_mid_wait();
        test_clk_out();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 2000000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
